// File: rtl/pipe_pkg.sv
// Shared widths, EX/MEM field offsets and helpers for pipe_stage_reg.
// Optional skid buffer enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

    localparam int DEF_DATA_W  = 101;
    localparam int DEF_CTRL_W  = 5;
    localparam int STALL_CNT_W = 16;

    // EX/MEM data packing: {ALUout, PC+4, WriteData, WriteAddress}
    localparam int WADDR_W    = 5;
    localparam int WORD_W     = 32;
    localparam int WADDR_LSB  = 0;
    localparam int WDATA_LSB  = WADDR_LSB + WADDR_W;
    localparam int PC4_LSB    = WDATA_LSB + WORD_W;
    localparam int ALUOUT_LSB = PC4_LSB + WORD_W;

    // EX/MEM control packing: {RegWrite, MemRead, MemWrite, MemtoReg[1:0]}
    localparam int CTRL_MEMTOREG_LSB = 0;
    localparam int CTRL_MEMWRITE     = 2;
    localparam int CTRL_MEMREAD      = 3;
    localparam int CTRL_REGWRITE     = 4;

    typedef logic [DEF_DATA_W-1:0] ex_mem_data_t;
    typedef logic [DEF_CTRL_W-1:0] ex_mem_ctrl_t;

    function automatic ex_mem_data_t pack_ex_mem(
        input logic [WORD_W-1:0]  alu_out,
        input logic [WORD_W-1:0]  pc4,
        input logic [WORD_W-1:0]  wdata,
        input logic [WADDR_W-1:0] waddr
    );
        return {alu_out, pc4, wdata, waddr};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus control and data registers.
// Ports: clear (flush to empty/zero), load, drop (empty, data held); ctrl reads BUBBLE_CTRL when empty.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            ctrl_q <= BUBBLE_CTRL;
            data   <= '0;
        end else begin
            priority case (1'b1)
                clear: begin
                    valid  <= 1'b0;
                    ctrl_q <= BUBBLE_CTRL;
                    data   <= '0;
                end
                load: begin
                    valid  <= 1'b1;
                    ctrl_q <= ld_ctrl;
                    data   <= ld_data;
                end
                drop: begin
                    valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ctrl = valid ? ctrl_q : BUBBLE_CTRL;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and stall counter.
// Ports: in_* upstream, out_* downstream, flush, stall_cnt. Macro PIPE_STAGE_SKID_EN adds a skid slot.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic              acc;
    logic              emit;
    logic              m_valid;
    logic              m_load;
    logic              m_drop;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ld_ctrl;
    logic [DATA_W-1:0] m_ld_data;

    assign acc  = in_valid && in_ready;
    assign emit = m_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic              s_load;
    logic              s_drop;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    // in_ready comes straight from the skid flag register, so nothing
    // combinational from out_ready reaches it. Accepts only happen with
    // the skid empty.
    assign in_ready = !s_valid;

    always_comb begin
        m_load    = 1'b0;
        m_drop    = 1'b0;
        s_load    = 1'b0;
        s_drop    = 1'b0;
        m_ld_ctrl = in_ctrl;
        m_ld_data = in_data;
        priority case (1'b1)
            s_valid && emit: begin
                m_load    = 1'b1;
                m_ld_ctrl = s_ctrl;
                m_ld_data = s_data;
                s_drop    = 1'b1;
            end
            acc && (!m_valid || emit): begin
                m_load = 1'b1;
            end
            acc: begin
                s_load = 1'b1;
            end
            emit: begin
                m_drop = 1'b1;
            end
            default: begin
            end
        endcase
    end

    pipe_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (s_load),
        .drop    (s_drop),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
    );
`else
    assign in_ready  = !m_valid || out_ready;
    assign m_load    = acc;
    assign m_drop    = emit && !acc;
    assign m_ld_ctrl = in_ctrl;
    assign m_ld_data = in_data;
`endif

    pipe_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (m_load),
        .drop    (m_drop),
        .ld_ctrl (m_ld_ctrl),
        .ld_data (m_ld_data),
        .valid   (m_valid),
        .ctrl    (m_ctrl),
        .data    (m_data)
    );

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    // Counts the flush cycle too; saturates, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg.
// Skid-specific sequences follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int CW = DEF_CTRL_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [CW-1:0] ictrl;
        logic [DW-1:0] idata;
        logic          ev;
        logic [CW-1:0] ectrl;
        logic [DW-1:0] edata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1ns after the edge; registered outputs are read there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

`ifndef PIPE_STAGE_SKID_EN
    logic          mv;
    logic [DW-1:0] md;
    logic [DW-1:0] nd;
    logic [DW-1:0] next_out;
    logic          acc_m;
    logic          ord[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        idle();
        reset = 1'b0;
        #2;
        do_reset();

        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_ctrl", out_ctrl, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_in_ready", in_ready, 1);

        // Stream 1..8 at full rate, then an idle cycle.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 1'b1, CW'(i + 1), DW'(i + 1),
                        1'b1, CW'(i + 1), DW'(i + 1)};
        end
        vecs[8] = '{1'b0, 1'b1, '0, '0, 1'b0, '0, DW'(8)};

        for (int i = 0; i < 9; i++) begin
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_ctrl   = vecs[i].ictrl;
            in_data   = vecs[i].idata;
            tick();
            chk($sformatf("stream%0d_valid", i), out_valid, vecs[i].ev);
            chk($sformatf("stream%0d_ctrl", i), out_ctrl, vecs[i].ectrl);
            chk($sformatf("stream%0d_data", i), out_data, vecs[i].edata);
        end
        chk("stream_stall_cnt", stall_cnt, 0);

        // Back-pressure: A then B, downstream stalls from A's first cycle.
        in_valid = 1'b1;
        in_data  = DW'(8'h11);
        in_ctrl  = 5'b00001;
        tick();
        in_data   = DW'(8'h22);
        in_ctrl   = 5'b00010;
        out_ready = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready_skid_full", in_ready, 0);
        chk("bp_hold_a", out_data, DW'(8'h11));
        tick();
        tick();
        chk("bp_stall_cnt", stall_cnt, 3);
        out_ready = 1'b1;
        tick();
        chk("bp_emit_b_valid", out_valid, 1);
        chk("bp_emit_b_data", out_data, DW'(8'h22));
        tick();
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_drain_in_ready", in_ready, 1);
`else
        #1;
        chk("bp_in_ready_comb_low", in_ready, 0);
        tick();
        tick();
        tick();
        chk("bp_stall_cnt", stall_cnt, 3);
        chk("bp_hold_a", out_data, DW'(8'h11));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb_high", in_ready, 1);
        tick();
        chk("bp_emit_b_valid", out_valid, 1);
        chk("bp_emit_b_data", out_data, DW'(8'h22));
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", out_valid, 0);
`endif
        chk("bp_stall_cnt_final", stall_cnt, 3);

        // Flush during a capture cycle.
        in_valid  = 1'b1;
        in_ctrl   = 5'b10111;
        in_data   = DW'(8'h55);
        out_ready = 1'b1;
        tick();
        chk("fl_pre_ctrl", out_ctrl, 5'b10111);
        flush     = 1'b1;
        in_ctrl   = 5'b00001;
        in_data   = DW'(8'h66);
        out_ready = 1'b0;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_data", out_data, 0);
        chk("fl_stall_cnt", stall_cnt, 4);
        idle();
        tick();
        tick();
        chk("fl_no_emit_valid", out_valid, 0);
        chk("fl_no_emit_data", out_data, 0);

        // Async reset between edges with the stage full.
        in_valid  = 1'b1;
        in_ctrl   = 5'b00011;
        in_data   = DW'(8'h33);
        out_ready = 1'b0;
        tick();
        in_data = DW'(8'h44);
        tick();
        chk("ar_pre_valid", out_valid, 1);
`ifdef PIPE_STAGE_SKID_EN
        chk("ar_pre_in_ready", in_ready, 0);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ctrl", out_ctrl, 0);
        chk("ar_data", out_data, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        chk("ar_in_ready", in_ready, 1);
        #1;
        reset = 1'b0;
        idle();
        tick();
        tick();
        chk("ar_after_valid", out_valid, 0);

`ifndef PIPE_STAGE_SKID_EN
        // Combinational in_ready and ordering under toggling out_ready.
        mv       = 1'b0;
        md       = '0;
        nd       = DW'(8'h80);
        next_out = DW'(8'h80);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data   = nd;
            in_ctrl   = 5'b00001;
            out_ready = ord[c % 4];
            #1;
            chk($sformatf("tg%0d_in_ready", c), in_ready, !mv || ord[c % 4]);
            acc_m = !mv || ord[c % 4];
            if (mv && ord[c % 4]) begin
                chk($sformatf("tg%0d_order", c), out_data, next_out);
                next_out = next_out + 1'b1;
            end
            tick();
            if (acc_m) begin
                mv = 1'b1;
                md = nd;
                nd = nd + 1'b1;
            end
            chk($sformatf("tg%0d_out_data", c), out_data, md);
        end
        idle();
        do_reset();
`endif

        // Saturation of the stall counter.
        in_valid  = 1'b1;
        in_data   = DW'(8'h77);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (65534) tick();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        repeat (10) tick();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        chk("sat_out_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("sat_reset_clear", stall_cnt, 0);
        reset = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
